sram_1rw_masked_pipe: RTL and testbench

//  Parametrised single-port (1RW) masked SRAM with a ready/valid request port, configurable read

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_1rw_array.sv | 45 ++++
 rtl/sram_1rw_masked_pipe.sv | 156 +++++++++++++++
 tb/tb_sram_1rw_masked_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the masked 1RW SRAM: FSM encoding, read-latency range and
// an elaboration-time parameter check usable inside module bodies.
`ifndef SRAM_PKG_SV
`define SRAM_PKG_SV

`define SRAM_ELAB_CHECK(W, M, L) \
  if ((((W) % (M)) != 0) || ((L) < sram_pkg::READ_LAT_MIN) || ((L) > sram_pkg::READ_LAT_MAX)) begin : g_param_err \
    $error("sram: WIDTH must be a multiple of MASK_SEGS and READ_LAT must be within 1..3"); \
  end

package sram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1
  } state_t;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

endpackage

`endif

// File: rtl/sram_1rw_array.sv
// Behavioural DEPTH x WIDTH storage with per-segment write mask; read data is captured
// at the access edge, so a later write never disturbs an already-issued read.
module sram_1rw_array #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 328,
  parameter int unsigned MASK_SEGS = 4
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [MASK_SEGS-1:0]     wmask,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  localparam int unsigned SEG_W = WIDTH / MASK_SEGS;

  logic [WIDTH-1:0] mem [DEPTH];

`ifdef RANDOMIZE_MEM_INIT
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        mem[i][j] = 1'($urandom);
      end
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < MASK_SEGS; i++) begin
          if (wmask[i]) begin
            mem[addr][i*SEG_W +: SEG_W] <= wdata[i*SEG_W +: SEG_W];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_1rw_masked_pipe.sv
// Masked 1RW SRAM with ready/valid requests, READ_LAT-deep read pipeline, optional
// hold of the last read word and a reset-time zero-fill sequencer.
module sram_1rw_masked_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WIDTH     = 328,
  parameter int unsigned MASK_SEGS = 4,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned INIT_ZERO = 1,
  parameter int unsigned HOLD_READ = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [MASK_SEGS-1:0]     req_wmask,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     init_done
);

  localparam int unsigned    AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  `SRAM_ELAB_CHECK(WIDTH, MASK_SEGS, READ_LAT)

  state_t                 state;
  logic [AW-1:0]          cnt;
  logic                   fire;
  logic                   rd_fire;
  logic                   arr_en;
  logic                   arr_we;
  logic [AW-1:0]          arr_addr;
  logic [MASK_SEGS-1:0]   arr_wmask;
  logic [WIDTH-1:0]       arr_wdata;
  logic [WIDTH-1:0]       rdata;
  logic [WIDTH-1:0]       last_data;
  logic [READ_LAT-1:0]    vld;
  logic                   seen;

  assign fire    = req_valid & req_ready;
  assign rd_fire = fire & ~req_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      cnt       <= '0;
      req_ready <= (INIT_ZERO == 0);
      init_done <= (INIT_ZERO == 0);
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST_ADDR) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: ;
        default: state <= ST_INIT;
      endcase
    end
  end

  // The zero-fill sequencer owns the single port while in INIT (req_ready is low then).
  always_comb begin
    arr_en    = fire;
    arr_we    = req_write;
    arr_addr  = req_addr;
    arr_wmask = req_wmask;
    arr_wdata = req_wdata;
    if (state == ST_INIT) begin
      arr_en    = 1'b1;
      arr_we    = 1'b1;
      arr_addr  = cnt;
      arr_wmask = '1;
      arr_wdata = '0;
    end
  end

  sram_1rw_array #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_SEGS (MASK_SEGS)
  ) u_array (
    .clock (clock),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wmask (arr_wmask),
    .wdata (arr_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= rd_fire;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Stage k only loads when the word in front of it is valid, so the last stage
  // naturally holds the most recent response.
  if (READ_LAT == 1) begin : g_direct
    assign last_data = rdata;
  end else begin : g_stages
    logic [WIDTH-1:0] stage [READ_LAT-1];

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int unsigned k = 0; k < READ_LAT - 1; k++) begin
          stage[k] <= '0;
        end
      end else begin
        if (vld[0]) begin
          stage[0] <= rdata;
        end
        for (int unsigned k = 1; k < READ_LAT - 1; k++) begin
          if (vld[k]) begin
            stage[k] <= stage[k-1];
          end
        end
      end
    end

    assign last_data = stage[READ_LAT-2];
  end

  assign resp_valid = vld[READ_LAT-1];

  // Masks the unreset array output until a response has actually been produced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen <= 1'b0;
    end else if (resp_valid) begin
      seen <= 1'b1;
    end
  end

  always_comb begin
    resp_data = '0;
    if (resp_valid || ((HOLD_READ != 0) && seen)) begin
      resp_data = last_data;
    end
  end

endmodule

// File: tb/tb_sram_1rw_masked_pipe.sv
// Bench: two instances (READ_LAT=3/hold, READ_LAT=1/zero) driven by the same requests
// and compared every cycle against an array-plus-schedule reference model.
module tb_sram_1rw_masked_pipe;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WIDTH = 328;
  localparam int unsigned SEGS  = 4;
  localparam int unsigned SEG_W = WIDTH / SEGS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          LAT_A = 3;
  localparam int          LAT_B = 1;

  localparam logic [WIDTH-1:0] P_AA  = {41{8'hAA}};
  localparam logic [WIDTH-1:0] P_55  = {41{8'h55}};
  localparam logic [WIDTH-1:0] P_MIX = {{41{2'b10}}, {41{2'b01}}, {41{2'b10}}, {41{2'b01}}};
  localparam logic [WIDTH-1:0] P_11  = {41{8'h11}};
  localparam logic [WIDTH-1:0] P_22  = {41{8'h22}};
  localparam logic [WIDTH-1:0] P_33  = {41{8'h33}};
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_write = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [SEGS-1:0]  req_wmask = '0;
  logic [WIDTH-1:0] req_wdata = '0;

  logic             req_ready_a, resp_valid_a, init_done_a;
  logic             req_ready_b, resp_valid_b, init_done_b;
  logic [WIDTH-1:0] resp_data_a, resp_data_b;

  always #5 clock = ~clock;

  sram_1rw_masked_pipe #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEGS(SEGS),
    .READ_LAT(LAT_A), .INIT_ZERO(1), .HOLD_READ(1)
  ) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_data(resp_data_a), .init_done(init_done_a)
  );

  sram_1rw_masked_pipe #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEGS(SEGS),
    .READ_LAT(LAT_B), .INIT_ZERO(1), .HOLD_READ(0)
  ) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b), .init_done(init_done_b)
  );

  // Reference model: plain memory, expected responses keyed by the cycle they appear in.
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] sched_a [int];
  logic [WIDTH-1:0] sched_b [int];
  logic [WIDTH-1:0] tbl_a [int];
  logic [WIDTH-1:0] tbl_b [int];
  logic [WIDTH-1:0] held_a;
  int cyc = 0;
  int since_reset = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic             wr;
    logic [AW-1:0]    addr;
    logic [SEGS-1:0]  mask;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, WIDTH'(act), WIDTH'(exp));
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    return t[WIDTH-1:0];
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    #2;
    chk1("rst_ready_a", req_ready_a, 1'b0);
    chk1("rst_init_done_a", init_done_a, 1'b0);
    chk1("rst_resp_valid_a", resp_valid_a, 1'b0);
    chk1("rst_ready_b", req_ready_b, 1'b0);
    chk1("rst_resp_valid_b", resp_valid_b, 1'b0);
    chk("rst_resp_data_a", resp_data_a, '0);
    chk("rst_resp_data_b", resp_data_b, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    sched_a.delete();
    sched_b.delete();
    tbl_a.delete();
    tbl_b.delete();
    held_a = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    since_reset = 0;
  endtask

  // One clock cycle with the given request; outputs are checked #1 after the edge.
  task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [SEGS-1:0] m, input logic [WIDTH-1:0] d);
    logic             rdy;
    logic             va, vb;
    logic [WIDTH-1:0] eb;
    rdy       = (since_reset >= DEPTH);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    @(posedge clock);
    #1;
    if (v && rdy) begin
      if (w) begin
        for (int i = 0; i < SEGS; i++)
          if (m[i]) model_mem[a][i*SEG_W +: SEG_W] = d[i*SEG_W +: SEG_W];
      end else begin
        sched_a[cyc + LAT_A] = model_mem[a];
        sched_b[cyc + LAT_B] = model_mem[a];
      end
    end
    cyc++;
    since_reset++;
    req_valid = 1'b0;

    rdy = (since_reset >= DEPTH);
    chk1("ready_a", req_ready_a, rdy);
    chk1("init_done_a", init_done_a, rdy);
    chk1("ready_b", req_ready_b, rdy);
    chk1("init_done_b", init_done_b, rdy);

    va = sched_a.exists(cyc);
    if (va) begin
      held_a = sched_a[cyc];
      sched_a.delete(cyc);
    end
    chk1("resp_valid_a", resp_valid_a, va);
    chk("resp_data_a", resp_data_a, held_a);

    vb = sched_b.exists(cyc);
    eb = '0;
    if (vb) begin
      eb = sched_b[cyc];
      sched_b.delete(cyc);
    end
    chk1("resp_valid_b", resp_valid_b, vb);
    chk("resp_data_b", resp_data_b, eb);

    if (tbl_a.exists(cyc)) begin
      chk("tbl_data_a", resp_data_a, tbl_a[cyc]);
      tbl_a.delete(cyc);
    end
    if (tbl_b.exists(cyc)) begin
      chk("tbl_data_b", resp_data_b, tbl_b[cyc]);
      tbl_b.delete(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    tbl.push_back('{1'b1, AW'(5),  4'b1111, P_AA,     '0});
    tbl.push_back('{1'b1, AW'(5),  4'b0101, P_55,     '0});
    tbl.push_back('{1'b0, AW'(5),  4'b0000, '0,       P_MIX});
    tbl.push_back('{1'b1, AW'(7),  4'b1111, ONE,      '0});
    tbl.push_back('{1'b0, AW'(7),  4'b0000, '0,       ONE});
    tbl.push_back('{1'b1, AW'(7),  4'b1111, TWO,      '0});
    tbl.push_back('{1'b0, AW'(7),  4'b0000, '0,       TWO});
    tbl.push_back('{1'b0, AW'(0),  4'b0000, '0,       '0});
    tbl.push_back('{1'b1, AW'(9),  4'b0000, '1,       '0});
    tbl.push_back('{1'b0, AW'(9),  4'b0000, '0,       '0});
    tbl.push_back('{1'b0, AW'(63), 4'b0000, '0,       '0});
    tbl.push_back('{1'b1, AW'(1),  4'b1111, P_11,     '0});
    tbl.push_back('{1'b1, AW'(2),  4'b1111, P_22,     '0});
    tbl.push_back('{1'b1, AW'(3),  4'b1111, P_33,     '0});
    tbl.push_back('{1'b0, AW'(1),  4'b0000, '0,       P_11});
    tbl.push_back('{1'b0, AW'(2),  4'b0000, '0,       P_22});
    tbl.push_back('{1'b0, AW'(3),  4'b0000, '0,       P_33});

    // Power-on reset and full zero-fill.
    do_reset();
    idle(DEPTH + 4);

    // Directed vectors, applied back-to-back.
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].wr) begin
        tbl_a[cyc + LAT_A] = tbl[i].exp;
        tbl_b[cyc + LAT_B] = tbl[i].exp;
      end
      cycle(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].data);
    end
    idle(5);

    // Reset with two reads in flight: no responses may emerge, init restarts.
    cycle(1'b1, 1'b0, AW'(1), '0, '0);
    cycle(1'b1, 1'b0, AW'(2), '0, '0);
    do_reset();
    idle(DEPTH + 4);

    // Reset partway through the zero-fill.
    do_reset();
    idle(40);
    do_reset();
    idle(DEPTH + 4);

    // Randomised traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 1'($urandom), AW'($urandom % 16), SEGS'($urandom), rnd_word());
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
